elastic_buffer_read_ctrl: RTL and testbench

ELASTIC_BUFFER_READ_CTRL -- requirements
Module: elastic_buffer_read_ctrl

---
 rtl/eb_pkg.sv | 20 ++
 rtl/gray2bin.sv | 17 +
 rtl/elastic_buffer_read_ctrl.sv | 157 +++++++++++++++
 tb/tb_elastic_buffer_read_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eb_pkg.sv
// Purpose: shared types and default thresholds for the elastic buffer read side.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eb_pkg;

  // Read-side controller states.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    INSERT = 2'd2,
    DELETE = 2'd3
  } eb_state_e;

  localparam int unsigned EB_ADDR_W_DEF  = 4;
  localparam int unsigned EB_DATA_W_DEF  = 10;
  localparam int unsigned EB_FILL_TH_DEF = 8;
  localparam int unsigned EB_LOW_TH_DEF  = 6;
  localparam int unsigned EB_HIGH_TH_DEF = 10;

endpackage

// File: rtl/gray2bin.sv
// Purpose: combinational Gray-code to binary converter.
// Latency: zero cycles (purely combinational).
// Backpressure: none.
// Ports: gray (W-bit Gray input), bin (W-bit binary output).
module gray2bin #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/elastic_buffer_read_ctrl.sv
// Purpose: read-side controller of a clock-compensating elastic buffer, inserting or
//          deleting one SKP symbol per SKP run to keep the fill level inside a window.
// Latency: rd_req to data_valid is 1 cycle in RUN, 2 cycles through INSERT.
// Backpressure: consumer pulls with rd_req; rd_req=0 holds the pointer and state.
// Ports: clk/rst (sync, active-high); gray_counter_write_sync (synced write ptr);
//        rd_data_in/is_skp_in (memory word at rd_addr); rd_req; rd_addr;
//        gray_counter_read; data_out/data_valid; skp_added/skp_removed/underflow/
//        overflow pulses; level; err_cnt {overflow[15:8], underflow[7:0]}.
// Optional: define EB_ERR_STATS_EN to enable the saturating error counters.
module elastic_buffer_read_ctrl
  import eb_pkg::*;
#(
  parameter int unsigned ADDR_W  = EB_ADDR_W_DEF,
  parameter int unsigned DATA_W  = EB_DATA_W_DEF,
  parameter int unsigned FILL_TH = EB_FILL_TH_DEF,
  parameter int unsigned LOW_TH  = EB_LOW_TH_DEF,
  parameter int unsigned HIGH_TH = EB_HIGH_TH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   gray_counter_write_sync,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic              is_skp_in,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   gray_counter_read,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              skp_added,
  output logic              skp_removed,
  output logic              underflow,
  output logic              overflow,
  output logic [ADDR_W:0]   level,
  output logic [15:0]       err_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] FILL_TH_L = FILL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] LOW_TH_L  = LOW_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] HIGH_TH_L = HIGH_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_L     = {{ADDR_W{1'b0}}, 1'b1};

  eb_state_e         state_q, state_d;
  logic [ADDR_W:0]   rd_bin_q, rd_bin_d;
  logic [ADDR_W:0]   wr_bin;
  logic              adj_done_q, adj_done_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, added_d, removed_d, udf_d, ovf_d;
  logic              empty, full;

  gray2bin #(.W(ADDR_W + 1)) u_wr_g2b (
    .gray (gray_counter_write_sync),
    .bin  (wr_bin)
  );

  // Pointers carry one extra wrap bit, so the modular difference is the occupancy.
  assign level   = wr_bin - rd_bin_q;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH_L);
  assign ovf_d   = full | (level > DEPTH_L);
  assign rd_addr = rd_bin_q[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    rd_bin_d   = rd_bin_q;
    adj_done_d = adj_done_q;
    data_d     = data_out;
    valid_d    = 1'b0;
    added_d    = 1'b0;
    removed_d  = 1'b0;
    udf_d      = 1'b0;
    case (state_q)
      FILL: begin
        if (level >= FILL_TH_L) state_d = RUN;
      end
      RUN: begin
        if (rd_req) begin
          if (empty) begin
            udf_d   = 1'b1;
            state_d = FILL;
          end else if (is_skp_in && !adj_done_q && (level < LOW_TH_L)) begin
            state_d = INSERT;
          end else if (is_skp_in && !adj_done_q && (level > HIGH_TH_L)) begin
            state_d = DELETE;
          end else begin
            data_d   = rd_data_in;
            valid_d  = 1'b1;
            rd_bin_d = rd_bin_q + ONE_L;
            // A non-SKP symbol ends the SKP run and re-arms adjustment.
            if (!is_skp_in) adj_done_d = 1'b0;
          end
        end
      end
      INSERT: begin
        // Emit the head SKP but leave it in place: RUN will read it again.
        data_d     = rd_data_in;
        valid_d    = 1'b1;
        added_d    = 1'b1;
        adj_done_d = 1'b1;
        state_d    = RUN;
      end
      DELETE: begin
        rd_bin_d   = rd_bin_q + ONE_L;
        removed_d  = 1'b1;
        adj_done_d = 1'b1;
        state_d    = RUN;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= FILL;
      rd_bin_q          <= '0;
      gray_counter_read <= '0;
      adj_done_q        <= 1'b0;
      data_out          <= '0;
      data_valid        <= 1'b0;
      skp_added         <= 1'b0;
      skp_removed       <= 1'b0;
      underflow         <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      state_q           <= state_d;
      rd_bin_q          <= rd_bin_d;
      gray_counter_read <= rd_bin_d ^ (rd_bin_d >> 1);
      adj_done_q        <= adj_done_d;
      data_out          <= data_d;
      data_valid        <= valid_d;
      skp_added         <= added_d;
      skp_removed       <= removed_d;
      underflow         <= udf_d;
      overflow          <= ovf_d;
    end
  end

`ifdef EB_ERR_STATS_EN
  logic [7:0] ovf_cnt, udf_cnt;

  // Counters step on the same edge that raises the matching pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (ovf_d && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
      if (udf_d && (udf_cnt != 8'hFF)) udf_cnt <= udf_cnt + 8'd1;
    end
  end

  assign err_cnt = {ovf_cnt, udf_cnt};
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_elastic_buffer_read_ctrl.sv
// Purpose: self-checking bench for elastic_buffer_read_ctrl against a queue-based model.
// Latency: model predicts registered outputs one edge after inputs are applied.
// Backpressure: bench drives rd_req directly and never overfills its memory.
module tb_elastic_buffer_read_ctrl;

  localparam int AW = 4;
  localparam int DW = 10;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic          skp;
    logic [DW-1:0] d;
  } sym_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   gray_counter_write_sync;
  logic [DW-1:0] rd_data_in;
  logic          is_skp_in;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   gray_counter_read;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          skp_added, skp_removed, underflow, overflow;
  logic [AW:0]   level;
  logic [15:0]   err_cnt;

  elastic_buffer_read_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .gray_counter_write_sync (gray_counter_write_sync),
    .rd_data_in              (rd_data_in),
    .is_skp_in               (is_skp_in),
    .rd_req                  (rd_req),
    .rd_addr                 (rd_addr),
    .gray_counter_read       (gray_counter_read),
    .data_out                (data_out),
    .data_valid              (data_valid),
    .skp_added               (skp_added),
    .skp_removed             (skp_removed),
    .underflow               (underflow),
    .overflow                (overflow),
    .level                   (level),
    .err_cnt                 (err_cnt)
  );

  always #5 clk = ~clk;

  // Buffer memory written by the bench acting as the write side.
  logic [DW-1:0] mem  [DEPTH];
  logic          skpm [DEPTH];
  logic [AW:0]   wr_ptr;

  assign gray_counter_write_sync = wr_ptr ^ (wr_ptr >> 1);
  assign rd_data_in = mem[rd_addr];
  assign is_skp_in  = skpm[rd_addr];

  // Reference model: unread symbols as a queue, plus the controller's mode.
  localparam int M_FILLING = 0;
  localparam int M_READING = 1;
  localparam int M_DUP     = 2;
  localparam int M_DROP    = 3;

  sym_t          q[$];
  int            m_mode;
  bit            m_adj;
  int            rp;
  bit            e_vld, e_add, e_rem, e_udf, e_ovf;
  logic [DW-1:0] e_dat;
  int            udf_c, ovf_c;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_sym(input logic [DW-1:0] d, input logic s);
    sym_t e;
    mem[wr_ptr[AW-1:0]]  = d;
    skpm[wr_ptr[AW-1:0]] = s;
    e.skp = s;
    e.d   = d;
    q.push_back(e);
    wr_ptr = wr_ptr + 1'b1;
  endtask

  task automatic model_reset();
    q.delete();
    wr_ptr = '0;
    m_mode = M_FILLING;
    m_adj  = 1'b0;
    rp     = 0;
    e_vld = 0; e_add = 0; e_rem = 0; e_udf = 0; e_ovf = 0;
    e_dat  = '0;
    udf_c  = 0;
    ovf_c  = 0;
  endtask

  task automatic model_step();
    int   lvl;
    sym_t h;
    lvl   = q.size();
    e_vld = 0; e_add = 0; e_rem = 0; e_udf = 0;
    e_ovf = (lvl >= DEPTH);
    case (m_mode)
      M_FILLING: if (lvl >= 8) m_mode = M_READING;
      M_READING: begin
        if (rd_req) begin
          if (lvl == 0) begin
            e_udf  = 1;
            m_mode = M_FILLING;
          end else begin
            h = q[0];
            if (h.skp && !m_adj && lvl < 6) m_mode = M_DUP;
            else if (h.skp && !m_adj && lvl > 10) m_mode = M_DROP;
            else begin
              e_vld = 1;
              e_dat = h.d;
              void'(q.pop_front());
              rp = (rp + 1) % 32;
              if (!h.skp) m_adj = 0;
            end
          end
        end
      end
      M_DUP: begin
        e_vld  = 1;
        e_dat  = q[0].d;
        e_add  = 1;
        m_adj  = 1;
        m_mode = M_READING;
      end
      default: begin
        void'(q.pop_front());
        rp     = (rp + 1) % 32;
        e_rem  = 1;
        m_adj  = 1;
        m_mode = M_READING;
      end
    endcase
    if (e_udf && udf_c < 255) udf_c++;
    if (e_ovf && ovf_c < 255) ovf_c++;
  endtask

  // One clock: predict, let the DUT take the edge, then compare.
  task automatic step();
    logic [4:0] rpv;
    logic [31:0] e_err;
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    rpv = rp[4:0];
`ifdef EB_ERR_STATS_EN
    e_err = {16'd0, ovf_c[7:0], udf_c[7:0]};
`else
    e_err = 32'd0;
`endif
    chk("data_valid",  data_valid,  e_vld);
    chk("data_out",    data_out,    e_dat);
    chk("skp_added",   skp_added,   e_add);
    chk("skp_removed", skp_removed, e_rem);
    chk("underflow",   underflow,   e_udf);
    chk("overflow",    overflow,    e_ovf);
    chk("level",       level,       q.size());
    chk("rd_addr",     rd_addr,     rpv[3:0]);
    chk("gray_rd",     gray_counter_read, rpv ^ (rpv >> 1));
    chk("err_cnt",     err_cnt,     e_err);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      skpm[i] = 1'b0;
    end
    wr_ptr = '0;
    rd_req = 1'b0;
    rst    = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;

    // Fill ramp with the consumer already asking: nothing until level 8, then in order.
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      write_sym(DW'($urandom), 1'b0);
      step();
    end
    repeat (12) step();

    // Low level with SKP at the head: one duplicated SKP, then drain into underflow.
    rd_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write_sym(DW'($urandom), i == 4);
      step();
    end
    rd_req = 1'b1;
    repeat (14) step();

    // High level with two leading SKPs: drop one, pass the second.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      write_sym(DW'($urandom), i < 2);
      step();
    end
    rd_req = 1'b1;
    repeat (6) step();

    // Fill to the top and sit there: overflow every cycle.
    rd_req = 1'b0;
    while (q.size() < DEPTH) begin
      write_sym(DW'($urandom), 1'b0);
      step();
    end
    repeat (4) step();

    // Random traffic, long enough for the read pointer to wrap several times.
    for (int n = 0; n < 800; n++) begin
      rd_req = ($urandom_range(0, 3) != 0);
      if (q.size() < DEPTH && $urandom_range(0, 1) == 1)
        write_sym(DW'($urandom), $urandom_range(0, 4) == 0);
      step();
    end

    // Reset landing while a SKP delete is pending.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      write_sym(DW'($urandom), i < 2);
      step();
    end
    rd_req = 1'b1;
    step();
    chk("mode_is_drop", m_mode, M_DROP);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_req = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
